// File: rtl/wb_bypass_buffer.sv
// ---------------------------------------------------------------------------
// wb_bypass_buffer
//
// Purpose:
//   This is the writeback-side forwarding store for the stage-1 operand muxes.
//   It records the last DEPTH committed register writes (rd, data) from stage 3
//   and answers zero-latency lookups for the rs1/rs2 operands of the stage-1
//   instruction.
//
//   It also tracks a load whose data returns late. While that data is
//   outstanding, the buffer refuses further writebacks. A stage-1 instruction
//   that reads the load destination is stalled until the data arrives.
//
// Parameters:
//   DEPTH  number of buffered writebacks (1..4); entry 0 is the newest
//   XLEN   data width
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            synchronous reset, active-low
//   wb_valid       stage 3 offers a register write
//   wb_ready       buffer accepts the offer (transfer = wb_valid && wb_ready)
//   wb_rd          destination register of the offered write
//   wb_data        write data (ignored for a pending load)
//   wb_pending     offered write is a load whose data arrives later
//   ld_data_valid  late load data present this cycle
//   ld_data        late load data
//   inst_s1        stage-1 instruction (rs1=[19:15], rs2=[24:20], opcode=[6:0])
//   fwd_sel_1/2    0 = take fwd_data_N, 1 = take the regfile value
//   fwd_data_1/2   forwarded operand values (0 when not forwarding)
//   stall_s1       stage 1 must hold; an operand waits on an unreturned load
//
// Optional feature (macro BYPASS_STATS_EN):
//   When defined, this adds the saturating counters stat_fwd_hits (cycles with
//   any forward) and stat_stall_cycles (cycles with stall_s1 high).
// ---------------------------------------------------------------------------
module wb_bypass_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_pending,
    input  logic            ld_data_valid,
    input  logic [XLEN-1:0] ld_data,
    input  logic [31:0]     inst_s1,
    output logic            fwd_sel_1,
    output logic            fwd_sel_2,
    output logic [XLEN-1:0] fwd_data_1,
    output logic [XLEN-1:0] fwd_data_2,
    output logic            stall_s1
`ifdef BYPASS_STATS_EN
    ,
    output logic [31:0]     stat_fwd_hits,
    output logic [31:0]     stat_stall_cycles
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    typedef struct packed {
        logic            hit;
        logic            rdy;
        logic [XLEN-1:0] data;
    } lookup_t;

    typedef struct packed {
        logic            sel;
        logic            stall;
        logic [XLEN-1:0] data;
    } resolve_t;

    state_t          state;
    state_t          state_nxt;

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_rdy;
    logic [4:0]       ent_rd   [DEPTH];
    logic [XLEN-1:0]  ent_data [DEPTH];

    logic            accept;
    logic            load_done;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_rs1;
    logic            use_rs2;
    resolve_t        res_1;
    resolve_t        res_2;

    logic            unused_inst;

    // ------------------------------------------------------------------
    // Lookup helpers.
    // Entries are scanned from oldest to newest, so the newest matching
    // entry overwrites any older one. Older entries with the same rd are
    // therefore shadowed.
    // ------------------------------------------------------------------
    function automatic lookup_t lookup(input logic [4:0] rs);
        lookup_t r;
        r = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_vld[i] && (ent_rd[i] == rs)) begin
                r.hit  = 1'b1;
                r.rdy  = ent_rdy[i];
                r.data = ent_data[i];
            end
        end
        return r;
    endfunction

    // A hit on the not-ready entry is satisfied directly from the load
    // return bus when the data arrives in the same cycle. Otherwise the
    // instruction stalls and the regfile path is selected.
    function automatic resolve_t resolve(input logic used, input logic [4:0] rs);
        resolve_t r;
        lookup_t  lk;
        r.sel   = 1'b1;
        r.stall = 1'b0;
        r.data  = '0;
        lk      = lookup(rs);
        if (used && (rs != 5'd0) && lk.hit) begin
            if (lk.rdy) begin
                r.sel  = 1'b0;
                r.data = lk.data;
            end else if (ld_data_valid) begin
                r.sel  = 1'b0;
                r.data = ld_data;
            end else begin
                r.stall = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ------------------------------------------------------------------
    // Writeback handshake / load tracking FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wb_ready  = 1'b0;
        case (state)
            IDLE: begin
                wb_ready = 1'b1;
                if (wb_valid && wb_pending && (wb_rd != 5'd0)) begin
                    state_nxt = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (ld_data_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A transfer to x0 completes the handshake but is not stored.
    assign accept    = wb_valid && wb_ready && (wb_rd != 5'd0);
    assign load_done = (state == WAIT_LOAD) && ld_data_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ent_vld <= '0;
            ent_rdy <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    ent_vld[i] <= ent_vld[i-1];
                    ent_rdy[i] <= ent_rdy[i-1];
                end
                ent_vld[0] <= 1'b1;
                ent_rdy[0] <= !wb_pending;
            end else if (load_done) begin
                // No shift can happen in WAIT_LOAD, so the pending entry is
                // still entry 0.
                ent_rdy[0] <= 1'b1;
            end
        end
    end

    // Data and tag storage is qualified by ent_vld and carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_rd[i]   <= ent_rd[i-1];
                ent_data[i] <= ent_data[i-1];
            end
            ent_rd[0]   <= wb_rd;
            ent_data[0] <= wb_data;
        end else if (load_done) begin
            ent_data[0] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage-1 operand decode and forwarding lookup (combinational)
    // ------------------------------------------------------------------
    assign opcode = inst_s1[6:0];
    assign rs1    = inst_s1[19:15];
    assign rs2    = inst_s1[24:20];

    assign unused_inst = ^{inst_s1[31:25], inst_s1[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR, OP_CSR: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    always_comb begin
        res_1 = resolve(use_rs1, rs1);
        res_2 = resolve(use_rs2, rs2);
    end

    assign fwd_sel_1  = res_1.sel;
    assign fwd_sel_2  = res_2.sel;
    assign fwd_data_1 = res_1.data;
    assign fwd_data_2 = res_2.data;
    assign stall_s1   = res_1.stall || res_2.stall;

`ifdef BYPASS_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fwd_hits     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (!fwd_sel_1 || !fwd_sel_2) begin
                stat_fwd_hits <= sat_inc(stat_fwd_hits);
            end
            if (stall_s1) begin
                stat_stall_cycles <= sat_inc(stat_stall_cycles);
            end
        end
    end
`else
    // Without statistics, the saturating increment helper is not instantiated.
`endif

endmodule

// File: tb/tb_wb_bypass_buffer.sv
module tb_wb_bypass_buffer;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk;
    logic            rst;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_pending;
    logic            ld_data_valid;
    logic [XLEN-1:0] ld_data;
    logic [31:0]     inst_s1;
    logic            fwd_sel_1;
    logic            fwd_sel_2;
    logic [XLEN-1:0] fwd_data_1;
    logic [XLEN-1:0] fwd_data_2;
    logic            stall_s1;
`ifdef BYPASS_STATS_EN
    logic [31:0]     stat_fwd_hits;
    logic [31:0]     stat_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_bypass_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_pending    (wb_pending),
        .ld_data_valid (ld_data_valid),
        .ld_data       (ld_data),
        .inst_s1       (inst_s1),
        .fwd_sel_1     (fwd_sel_1),
        .fwd_sel_2     (fwd_sel_2),
        .fwd_data_1    (fwd_data_1),
        .fwd_data_2    (fwd_data_2),
        .stall_s1      (stall_s1)
`ifdef BYPASS_STATS_EN
        ,
        .stat_fwd_hits     (stat_fwd_hits),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'b0, b, a, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_sw(input logic [4:0] src, input logic [4:0] base);
        return {7'b0, src, base, 3'b010, 5'b0, 7'b0100011};
    endfunction

    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
        return {imm, a, 3'b000, rd, 7'b0010011};
    endfunction

    // LUI with register-like bits in the rs1/rs2 fields; neither is an operand.
    function automatic logic [31:0] i_lui(input logic [4:0] rd, input logic [4:0] f1, input logic [4:0] f2);
        return {7'b0, f2, f1, 3'b000, rd, 7'b0110111};
    endfunction

    task automatic commit(input logic [4:0] rd, input logic [31:0] data, input logic pend);
        wb_valid   = 1'b1;
        wb_rd      = rd;
        wb_data    = data;
        wb_pending = pend;
        tick();
        wb_valid   = 1'b0;
        wb_pending = 1'b0;
        wb_data    = '0;
    endtask

    initial begin
        rst           = 1'b0;
        wb_valid      = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        wb_pending    = 1'b0;
        ld_data_valid = 1'b0;
        ld_data       = '0;
        inst_s1       = '0;
        tick();
        tick();
        rst = 1'b1;

        // Empty buffer after reset
        inst_s1 = i_add(5'd1, 5'd2, 5'd3);
        #1;
        check("rst_wb_ready", wb_ready, 1);
        check("rst_sel_1", fwd_sel_1, 1);
        check("rst_sel_2", fwd_sel_2, 1);
        check("rst_data_1", fwd_data_1, 0);
        check("rst_data_2", fwd_data_2, 0);
        check("rst_stall", stall_s1, 0);

        // Commit x5=0xAA; same-cycle lookup still sees the old contents
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_00AA; wb_pending = 1'b0;
        inst_s1  = i_add(5'd6, 5'd5, 5'd5);
        #1;
        check("same_cycle_sel_1", fwd_sel_1, 1);
        check("same_cycle_data_1", fwd_data_1, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("fwd_aa_sel_1", fwd_sel_1, 0);
        check("fwd_aa_sel_2", fwd_sel_2, 0);
        check("fwd_aa_data_1", fwd_data_1, 32'h0000_00AA);
        check("fwd_aa_data_2", fwd_data_2, 32'h0000_00AA);

        // Newest of several writes to the same register wins
        commit(5'd5, 32'h11, 1'b0);
        commit(5'd5, 32'h22, 1'b0);
        #1;
        check("newest_data_1", fwd_data_1, 32'h22);
        check("newest_data_2", fwd_data_2, 32'h22);

        // Writes to x0 are accepted and discarded
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
        #1;
        check("x0_wb_ready", wb_ready, 1);
        tick();
        wb_valid = 1'b0;
        inst_s1  = i_add(5'd1, 5'd0, 5'd5);
        #1;
        check("x0_sel_1", fwd_sel_1, 1);
        check("x0_data_1", fwd_data_1, 0);
        check("x0_kept_sel_2", fwd_sel_2, 0);
        check("x0_kept_data_2", fwd_data_2, 32'h22);

        // Opcode-based operand use
        inst_s1 = i_addi(5'd4, 5'd5, 12'h005);
        #1;
        check("addi_sel_1", fwd_sel_1, 0);
        check("addi_sel_2", fwd_sel_2, 1);
        check("addi_data_2", fwd_data_2, 0);
        inst_s1 = i_lui(5'd4, 5'd5, 5'd5);
        #1;
        check("lui_sel_1", fwd_sel_1, 1);
        check("lui_sel_2", fwd_sel_2, 1);

        // Pending load to x7, then a dependent store stalls
        commit(5'd7, 32'h0BAD_0BAD, 1'b1);
        inst_s1 = i_sw(5'd7, 5'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("wait_stall_%0d", c), stall_s1, 1);
            check($sformatf("wait_ready_%0d", c), wb_ready, 0);
            check($sformatf("wait_sel_2_%0d", c), fwd_sel_2, 1);
            check($sformatf("wait_sel_1_%0d", c), fwd_sel_1, 1);
            tick();
        end
        ld_data_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        #1;
        check("ld_ret_sel_2", fwd_sel_2, 0);
        check("ld_ret_data_2", fwd_data_2, 32'hDEAD_BEEF);
        check("ld_ret_stall", stall_s1, 0);
        tick();
        ld_data_valid = 1'b0; ld_data = '0;
        #1;
        check("post_ld_ready", wb_ready, 1);
        check("post_ld_sel_2", fwd_sel_2, 0);
        check("post_ld_data_2", fwd_data_2, 32'hDEAD_BEEF);

        // Late-load data in IDLE is ignored
        ld_data_valid = 1'b1; ld_data = 32'h0000_1234;
        tick();
        ld_data_valid = 1'b0; ld_data = '0;
        #1;
        check("idle_ld_data_2", fwd_data_2, 32'hDEAD_BEEF);
        check("idle_ld_ready", wb_ready, 1);

        // DEPTH=2: the third write pushes x1 out
        commit(5'd1, 32'h101, 1'b0);
        commit(5'd2, 32'h202, 1'b0);
        commit(5'd3, 32'h303, 1'b0);
        inst_s1 = i_add(5'd4, 5'd1, 5'd2);
        #1;
        check("evict_sel_1", fwd_sel_1, 1);
        check("evict_data_1", fwd_data_1, 0);
        check("evict_data_2", fwd_data_2, 32'h202);
        inst_s1 = i_add(5'd4, 5'd3, 5'd3);
        #1;
        check("evict_x3", fwd_data_1, 32'h303);

        // Reset while waiting for a load
        commit(5'd9, 32'h0, 1'b1);
        inst_s1 = i_add(5'd4, 5'd9, 5'd3);
        #1;
        check("rw_ready_pre", wb_ready, 0);
        check("rw_stall_pre", stall_s1, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rw_ready", wb_ready, 1);
        check("rw_stall", stall_s1, 0);
        check("rw_sel_1", fwd_sel_1, 1);
        check("rw_sel_2_cleared", fwd_sel_2, 1);
        ld_data_valid = 1'b1; ld_data = 32'h0000_0BAD;
        #1;
        check("rw_late_sel_1", fwd_sel_1, 1);
        check("rw_late_data_1", fwd_data_1, 0);
        tick();
        ld_data_valid = 1'b0; ld_data = '0;
        #1;
        check("rw_after_ready", wb_ready, 1);
        check("rw_after_sel_1", fwd_sel_1, 1);
        check("rw_after_stall", stall_s1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
